mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one single-ported, variable-latency memory between instruction fetch (IF)
//  and the MEM stage, whose load/store comes from the EX/MEM pipeline register.
//  Serialises accesses, returns read data, and drives stall_o to freeze PC, IF/ID,
//  ID/EX and EX/MEM until every access needed this cycle has completed.
// PARAMETERS
//  ADDR_W  32  address width, all ports
//  DATA_W  32  data width, all ports
// PORTS
//  clk_i        in   1       clock, rising edge
//  rst_i        in   1       reset, asynchronous, active-low
//  if_req_i     in   1       fetch request, level; held while stalled
//  if_addr_i    in   ADDR_W  fetch address (PC)
//  if_rdata_o   out  DATA_W  fetched instruction, registered
//  if_valid_o   out  1       1-cycle pulse: if_rdata_o updated
//  dm_read_i    in   1       load request (EX/MEM MemRead)
//  dm_write_i   in   1       store request (EX/MEM MemWrite)
//  dm_addr_i    in   ADDR_W  data address (EX/MEM ALU result)
//  dm_wdata_i   in   DATA_W  store data
//  dm_rdata_o   out  DATA_W  load data, registered
//  dm_valid_o   out  1       1-cycle pulse: data access completed
//  mem_req_o    out  1       memory request, registered
//  mem_we_o     out  1       1 = write
//  mem_addr_o   out  ADDR_W  memory address
//  mem_wdata_o  out  DATA_W  memory write data
//  mem_rdata_i  in   DATA_W  memory read data, valid with mem_ack_i
//  mem_ack_i    in   1       completion, 1 cycle, only while mem_req_o=1
//  stall_o      out  1       freeze pipeline registers and PC
// BEHAVIOUR
//  - Reset (async, rst_i=0): state IDLE; all outputs 0; done flags cleared.
//    Reset mid-access drops mem_req_o immediately. The in-flight access is
//    abandoned and is not replayed.
//  - FSM states: IDLE, DATA, INST, RESP_D, RESP_I.
//  - need_d = dm_read_i|dm_write_i; need_i = if_req_i.
//  - IDLE: need_d & ~d_done -> DATA; else need_i & ~i_done -> INST; else stay.
//    Data has priority over fetch because it belongs to the older instruction.
//  - Entering DATA/INST: at the same edge, load mem_req_o=1 and mem_addr_o.
//    Also load mem_we_o=dm_write_i and mem_wdata_o=dm_wdata_i for data;
//    load mem_we_o=0 for fetch.
//    These stay stable until mem_ack_i.
//  - DATA/INST with mem_ack_i=1: at that edge, mem_req_o<=0, capture mem_rdata_i
//    into dm_rdata_o/if_rdata_o (captured on stores too), go to RESP_D/RESP_I.
//    mem_ack_i is accepted in the first cycle mem_req_o=1 (min latency 1).
//  - RESP_D/RESP_I: dm_valid_o/if_valid_o=1 for exactly this cycle.
//    At the closing edge set d_done/i_done and return to IDLE.
//    RESP is a mandatory 1-cycle turnaround; no new grant is made in RESP.
//  - stall_o (comb) = (need_d & ~(d_done|dm_valid_o)) | (need_i & ~(i_done|if_valid_o)).
//  - Advance: on any edge with stall_o=0, clear d_done and i_done, so the next
//    instruction's requests become eligible.
//  - A done requester is never re-granted while the pipeline is frozen, so a
//    held request is not duplicated.
//  - mem_ack_i outside DATA/INST is ignored. The rdata outputs hold their last
//    value between responses.
//  - Load and store both high is treated as a store (mem_we_o=1).
// TESTING
//  - Fetch only, addr 0x10, ack 3 cycles after req -> mem_req_o high 3 cycles,
//    mem_we_o=0, if_valid_o pulse with data 0x00A00093, stall_o low in pulse cycle.
//  - Load 0x100 + fetch 0x14 same cycle -> data granted first, stall_o held.
//    Fetch issues 2 cycles after data ack. stall_o drops in RESP_I, both done flags clear.
//  - Store 0x200 <= 0xDEADBEEF, ack latency 1 -> mem_we_o=1, addr/wdata stable, dm_valid_o pulse.
//  - Fetch done, load still pending with requests held -> no second fetch on mem_req_o.
//  - rst_i low during DATA before ack -> mem_req_o, stall_o, valids all 0 at once.
//    After release, IDLE with no stale valid.
//  - Back-to-back fetches 0x0, 0x4, 0x8 with ack latency 1 -> one access every
//    3 cycles, data matches per address.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported, variable-latency memory between fetch and MEM stage.
// Latency: grant on the edge after a request is seen in IDLE; valid pulse in the cycle after mem_ack_i.
// Backpressure: stall_o holds the pipeline frozen until every access needed this cycle has completed.
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  // instruction fetch port
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic [DATA_W-1:0] if_rdata_o,
  output logic              if_valid_o,
  // data port (driven from the EX/MEM pipeline register)
  input  logic              dm_read_i,
  input  logic              dm_write_i,
  input  logic [ADDR_W-1:0] dm_addr_i,
  input  logic [DATA_W-1:0] dm_wdata_i,
  output logic [DATA_W-1:0] dm_rdata_o,
  output logic              dm_valid_o,
  // shared memory port
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              mem_ack_i,
  // pipeline freeze
  output logic              stall_o
);

  // RESP_D / RESP_I are a fixed one-cycle turnaround in which the response is
  // presented and no new grant is issued.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DATA   = 3'd1,
    S_INST   = 3'd2,
    S_RESP_D = 3'd3,
    S_RESP_I = 3'd4
  } state_e;

  state_e state_q, state_d;

  // Per-requester completion flags for the instruction currently held in
  // the pipeline; they stop a held request from being serviced twice.
  logic d_done_q, d_done_d;
  logic i_done_q, i_done_d;

  // Memory-side request registers, stable from grant until mem_ack_i.
  logic              mem_req_q,   mem_req_d;
  logic              mem_we_q,    mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

  // Response data registers; they hold their value between responses.
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;

  // need_data / need_inst: the requester has something to do for the
  // instruction currently presented by the pipeline.
  logic need_data;
  logic need_inst;
  logic if_valid;
  logic dm_valid;
  logic stall;

  // Decode requests and the one-cycle response pulses.
  always_comb begin
    need_data = dm_read_i | dm_write_i;
    need_inst = if_req_i;
    if_valid  = (state_q == S_RESP_I);
    dm_valid  = (state_q == S_RESP_D);
  end

  // Freeze while any needed access is still outstanding. The response cycle
  // itself counts as complete so the pipeline can advance on its closing edge.
  // Gated by reset so the freeze releases at once when reset is asserted.
  always_comb begin
    stall = rst_i &
            ((need_data & ~(d_done_q | dm_valid)) |
             (need_inst & ~(i_done_q | if_valid)));
  end

  // Next-state and memory-request logic; data wins ties because it belongs
  // to the older instruction.
  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;

    case (state_q)
      S_IDLE: begin
        if (need_data && !d_done_q) begin
          state_d     = S_DATA;
          mem_req_d   = 1'b1;
          // Load and store together resolve to a store.
          mem_we_d    = dm_write_i;
          mem_addr_d  = dm_addr_i;
          mem_wdata_d = dm_wdata_i;
        end else if (need_inst && !i_done_q) begin
          state_d    = S_INST;
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = if_addr_i;
        end
      end

      S_DATA: begin
        // Capture read data on stores too; callers ignore it in that case.
        if (mem_ack_i) begin
          state_d    = S_RESP_D;
          mem_req_d  = 1'b0;
          dm_rdata_d = mem_rdata_i;
        end
      end

      S_INST: begin
        if (mem_ack_i) begin
          state_d    = S_RESP_I;
          mem_req_d  = 1'b0;
          if_rdata_d = mem_rdata_i;
        end
      end

      S_RESP_D: begin
        state_d = S_IDLE;
      end

      S_RESP_I: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d   = S_IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  // Completion flags: set on leaving a response state, cleared whenever the
  // pipeline advances. Advancing wins, since the next instruction's requests
  // must be eligible straight away.
  always_comb begin
    d_done_d = d_done_q;
    i_done_d = i_done_q;
    if (!stall) begin
      d_done_d = 1'b0;
      i_done_d = 1'b0;
    end else begin
      if (state_q == S_RESP_D) d_done_d = 1'b1;
      if (state_q == S_RESP_I) i_done_d = 1'b1;
    end
  end

  // State and datapath registers; reset abandons any in-flight access.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= S_IDLE;
      d_done_q    <= 1'b0;
      i_done_q    <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      d_done_q    <= d_done_d;
      i_done_q    <= i_done_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
    end
  end

  // Drive outputs from registers and decoded state.
  always_comb begin
    mem_req_o   = mem_req_q;
    mem_we_o    = mem_we_q;
    mem_addr_o  = mem_addr_q;
    mem_wdata_o = mem_wdata_q;
    if_rdata_o  = if_rdata_q;
    dm_rdata_o  = dm_rdata_q;
    if_valid_o  = if_valid;
    dm_valid_o  = dm_valid;
    stall_o     = stall;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: drives pipeline "slots" (fetch plus optional load/store) into the arbiter.
// A bench-side memory answers with chosen or random latency; a monitor checks every access and response.
// Expected accesses come from a simple in-order model: data op first (older instruction), then fetch.
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b0;
  logic          if_req_i = 1'b0;
  logic [AW-1:0] if_addr_i = '0;
  logic [DW-1:0] if_rdata_o;
  logic          if_valid_o;
  logic          dm_read_i = 1'b0;
  logic          dm_write_i = 1'b0;
  logic [AW-1:0] dm_addr_i = '0;
  logic [DW-1:0] dm_wdata_i = '0;
  logic [DW-1:0] dm_rdata_o;
  logic          dm_valid_o;
  logic          mem_req_o;
  logic          mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_wdata_o;
  logic [DW-1:0] mem_rdata_i = '0;
  logic          mem_ack_i = 1'b0;
  logic          stall_o;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_rdata_o(if_rdata_o), .if_valid_o(if_valid_o),
    .dm_read_i(dm_read_i), .dm_write_i(dm_write_i), .dm_addr_i(dm_addr_i), .dm_wdata_i(dm_wdata_i),
    .dm_rdata_o(dm_rdata_o), .dm_valid_o(dm_valid_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i), .stall_o(stall_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        is_data;
    logic        second;
  } acc_t;

  typedef struct {
    logic        is_data;
    logic [31:0] data;
  } rsp_t;

  acc_t exp_acc[$];
  rsp_t exp_rsp[$];
  int   start_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int pend_cnt = 0;
  int cyc      = 0;
  int lat_cfg  = 0;
  int cur_lat  = 0;
  bit spur_en  = 1'b0;

  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] mem_arr [logic [31:0]];

  function automatic logic [31:0] init_val(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
  endfunction

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem_arr.exists(a) ? mem_arr[a] : init_val(a);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_true(input string name, input bit cond);
    n_checks++;
    if (!cond) begin
      n_fail++;
      $display("FAIL %s: condition false (cycle %0d)", name, cyc);
    end
  endtask

  task automatic finish_tb();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  endtask

  // Bench memory: counts latency from the first cycle it sees a request.
  bit busy = 1'b0;
  int cnt  = 0;
  always @(posedge clk_i) begin
    cyc++;
    #1;
    mem_ack_i   = 1'b0;
    mem_rdata_i = $urandom;
    if (!rst_i) begin
      busy = 1'b0;
    end else if (mem_req_o) begin
      if (!busy) begin
        busy    = 1'b1;
        cur_lat = (lat_cfg != 0) ? lat_cfg : int'($urandom_range(1, 4));
        cnt     = cur_lat;
      end
      cnt--;
      if (cnt == 0) begin
        mem_ack_i   = 1'b1;
        mem_rdata_i = mem_rd(mem_addr_o);
        if (mem_we_o) mem_arr[mem_addr_o] = mem_wdata_o;
      end
    end else begin
      busy = 1'b0;
      if (spur_en && $urandom_range(0, 9) == 0) mem_ack_i = 1'b1;
    end
  end

  // Monitor: checks accesses, responses and stall against the scoreboard.
  bit          req_prev = 1'b0;
  bit          ack_prev = 1'b0;
  int          hi_cnt = 0;
  int          last_ack_cyc = -100;
  logic        hold_we;
  logic [31:0] hold_addr, hold_wdata;
  logic [31:0] last_if = '0, last_dm = '0;
  acc_t        ma;
  rsp_t        mr;
  always @(negedge clk_i) begin
    if (!rst_i) begin
      req_prev = 1'b0;
      ack_prev = 1'b0;
      hi_cnt   = 0;
      last_if  = '0;
      last_dm  = '0;
    end else begin
      if (mem_req_o && !req_prev) begin
        start_q.push_back(cyc);
        check_true("acc_expected", exp_acc.size() != 0);
        if (exp_acc.size() != 0) begin
          ma = exp_acc.pop_front();
          check("acc_we", 32'(mem_we_o), 32'(ma.we));
          check("acc_addr", mem_addr_o, ma.addr);
          if (ma.is_data) check("acc_wdata", mem_wdata_o, ma.wdata);
          check_true("turnaround_min", (cyc - last_ack_cyc) >= 2);
          if (ma.second) check("turnaround_exact", 32'(cyc - last_ack_cyc), 32'd2);
        end
        hold_we    = mem_we_o;
        hold_addr  = mem_addr_o;
        hold_wdata = mem_wdata_o;
        hi_cnt     = 1;
      end else if (mem_req_o) begin
        check_true("req_drop_after_ack", !ack_prev);
        check("hold_addr", mem_addr_o, hold_addr);
        check("hold_we", 32'(mem_we_o), 32'(hold_we));
        check("hold_wdata", mem_wdata_o, hold_wdata);
        hi_cnt++;
      end else if (req_prev) begin
        check("req_hi_cycles", 32'(hi_cnt), 32'(cur_lat));
      end

      if (dm_valid_o || if_valid_o) begin
        check_true("valid_follows_ack", ack_prev);
        check_true("single_valid", !(dm_valid_o && if_valid_o));
        check_true("rsp_expected", exp_rsp.size() != 0);
        if (exp_rsp.size() != 0) begin
          mr = exp_rsp.pop_front();
          check("rsp_kind_is_data", 32'(dm_valid_o), 32'(mr.is_data));
          check("rsp_data", dm_valid_o ? dm_rdata_o : if_rdata_o, mr.data);
          pend_cnt--;
        end
        if (!dm_valid_o) check("dm_rdata_hold", dm_rdata_o, last_dm);
        if (!if_valid_o) check("if_rdata_hold", if_rdata_o, last_if);
      end else begin
        check("if_rdata_hold", if_rdata_o, last_if);
        check("dm_rdata_hold", dm_rdata_o, last_dm);
      end
      last_if = if_rdata_o;
      last_dm = dm_rdata_o;

      check("stall", 32'(stall_o), 32'(pend_cnt != 0));

      ack_prev = mem_ack_i && mem_req_o;
      if (ack_prev) last_ack_cyc = cyc + 1;
      req_prev = mem_req_o;
    end
  end

  task automatic push_data(input logic wr, input logic [31:0] da, input logic [31:0] wd, input logic sec);
    acc_t a;
    rsp_t r;
    a.we = wr; a.addr = da; a.wdata = wd; a.is_data = 1'b1; a.second = sec;
    r.is_data = 1'b1; r.data = ref_rd(da);
    exp_acc.push_back(a);
    exp_rsp.push_back(r);
    if (wr) ref_mem[da] = wd;
  endtask

  task automatic push_fetch(input logic [31:0] fa, input logic sec);
    acc_t a;
    rsp_t r;
    a.we = 1'b0; a.addr = fa; a.wdata = '0; a.is_data = 1'b0; a.second = sec;
    r.is_data = 1'b0; r.data = ref_rd(fa);
    exp_acc.push_back(a);
    exp_rsp.push_back(r);
  endtask

  // One pipeline slot. Called just after a rising edge; returns just after
  // the edge at which the pipeline advanced. dly>0 raises the data request
  // that many cycles after the fetch request.
  task automatic run_slot(input logic fe, input logic [31:0] fa, input logic rd, input logic wr,
                          input logic [31:0] da, input logic [31:0] wd, input int dly);
    bit dat;
    bit ok;
    dat = rd | wr;
    if (fe && dat && dly > 0) begin
      push_fetch(fa, 1'b0);
      push_data(wr, da, wd, 1'b1);
    end else begin
      if (dat) push_data(wr, da, wd, 1'b0);
      if (fe) push_fetch(fa, dat);
    end
    pend_cnt = int'(fe) + int'(dat);

    if_req_i  = fe;
    if_addr_i = fa;
    if (fe && dly > 0) repeat (dly) begin
      @(posedge clk_i);
      #1;
    end
    dm_read_i  = rd;
    dm_write_i = wr;
    dm_addr_i  = da;
    dm_wdata_i = wd;

    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk_i);
      #1;
      if (!stall_o) begin
        ok = 1'b1;
        break;
      end
    end
    check_true("slot_completes", ok);
    if (!ok) finish_tb();
    @(posedge clk_i);
    #1;
    if_req_i   = 1'b0;
    dm_read_i  = 1'b0;
    dm_write_i = 1'b0;
  endtask

  initial begin
    acc_t ra;
    bit   seen;
    bit   quiet;
    ref_mem[32'h10] = 32'h00A0_0093;
    mem_arr[32'h10] = 32'h00A0_0093;

    // Reset state, with a request asserted to show stall is released in reset.
    if_req_i = 1'b1;
    dm_read_i = 1'b1;
    repeat (2) @(negedge clk_i);
    check("rst_mem_req", 32'(mem_req_o), 32'd0);
    check("rst_mem_we", 32'(mem_we_o), 32'd0);
    check("rst_mem_addr", mem_addr_o, 32'd0);
    check("rst_stall", 32'(stall_o), 32'd0);
    check("rst_if_valid", 32'(if_valid_o), 32'd0);
    check("rst_dm_valid", 32'(dm_valid_o), 32'd0);
    check("rst_if_rdata", if_rdata_o, 32'd0);
    check("rst_dm_rdata", dm_rdata_o, 32'd0);
    if_req_i  = 1'b0;
    dm_read_i = 1'b0;
    #2 rst_i = 1'b1;
    @(posedge clk_i);
    #1;

    // Fetch only, latency 3.
    lat_cfg = 3;
    run_slot(1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0, 0);
    check("fetch_0x10_data", if_rdata_o, 32'h00A0_0093);

    // Load and fetch together: data first, fetch two cycles after data ack.
    lat_cfg = 2;
    run_slot(1'b1, 32'h14, 1'b1, 1'b0, 32'h100, 32'h0, 0);

    // Store with minimum latency.
    lat_cfg = 1;
    run_slot(1'b0, 32'h0, 1'b0, 1'b1, 32'h200, 32'hDEAD_BEEF, 0);
    check("store_reached_memory", mem_rd(32'h200), 32'hDEAD_BEEF);

    // Fetch granted first, load arrives while fetch is in flight: no refetch.
    lat_cfg = 3;
    run_slot(1'b1, 32'h18, 1'b1, 1'b0, 32'h200, 32'h0, 1);
    check("load_after_store", dm_rdata_o, 32'hDEAD_BEEF);

    // Load and store both high: treated as a store.
    lat_cfg = 2;
    run_slot(1'b1, 32'h1C, 1'b1, 1'b1, 32'h204, 32'hCAFE_F00D, 0);
    check("both_is_store", mem_rd(32'h204), 32'hCAFE_F00D);

    // Back-to-back fetches at latency 1: one access every 3 cycles.
    lat_cfg = 1;
    start_q.delete();
    for (int i = 0; i < 3; i++) run_slot(1'b1, 32'(i * 4), 1'b0, 1'b0, 32'h0, 32'h0, 0);
    check("b2b_count", 32'(start_q.size()), 32'd3);
    if (start_q.size() == 3) begin
      check("b2b_gap0", 32'(start_q[1] - start_q[0]), 32'd3);
      check("b2b_gap1", 32'(start_q[2] - start_q[1]), 32'd3);
    end

    // Reset in the middle of a data access.
    lat_cfg = 4;
    ra.we = 1'b0; ra.addr = 32'h300; ra.wdata = 32'h1234; ra.is_data = 1'b1; ra.second = 1'b0;
    exp_acc.push_back(ra);
    pend_cnt   = 1;
    dm_read_i  = 1'b1;
    dm_addr_i  = 32'h300;
    dm_wdata_i = 32'h1234;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_i);
      if (mem_req_o) begin
        seen = 1'b1;
        break;
      end
    end
    check_true("rst_mid_req_seen", seen);
    #2 rst_i = 1'b0;
    #1;
    check("midrst_mem_req", 32'(mem_req_o), 32'd0);
    check("midrst_stall", 32'(stall_o), 32'd0);
    check("midrst_if_valid", 32'(if_valid_o), 32'd0);
    check("midrst_dm_valid", 32'(dm_valid_o), 32'd0);
    exp_acc.delete();
    exp_rsp.delete();
    pend_cnt  = 0;
    dm_read_i = 1'b0;
    repeat (2) @(negedge clk_i);
    #2 rst_i = 1'b1;
    quiet = 1'b1;
    repeat (4) begin
      @(negedge clk_i);
      if (mem_req_o || if_valid_o || dm_valid_o || stall_o) quiet = 1'b0;
    end
    check_true("post_reset_quiet", quiet);
    @(posedge clk_i);
    #1;

    // Randomized slots with random latency and stray acks while idle.
    lat_cfg = 0;
    spur_en = 1'b1;
    for (int s = 0; s < 150; s++) begin
      int          op;
      logic        fe, rd, wr;
      logic [31:0] fa, da, wd;
      op = int'($urandom_range(0, 9));
      fe = ($urandom_range(0, 99) < 85);
      rd = (op == 5) || (op == 6) || (op == 9);
      wr = (op >= 7);
      fa = 32'($urandom_range(0, 15)) << 2;
      da = 32'h100 + (32'($urandom_range(0, 7)) << 2);
      wd = $urandom;
      run_slot(fe, fa, rd, wr, da, wd, (fe && (rd || wr) && $urandom_range(0, 4) == 0) ? 1 : 0);
    end
    spur_en = 1'b0;

    repeat (4) @(negedge clk_i);
    check("end_acc_queue_empty", 32'(exp_acc.size()), 32'd0);
    check("end_rsp_queue_empty", 32'(exp_rsp.size()), 32'd0);
    finish_tb();
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
